// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, line levels
// and the default frame width.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left-on-enable register exposing its MSB; the
// transmit-side counterpart of the serial-to-parallel shifter.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = shreg_q << 1;
        end
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[W-1];

endmodule

// File: rtl/uart_tx_8bit.sv
// UART transmitter: start bit, data MSB-first, optional even parity
// (UART_TX_PARITY_EN), STOP_BITS stop bits, paced by the baud tick en.
module uart_tx_8bit
    import uart_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              serial,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_t        state_q, state_d;
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift, msb;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    piso_shift_reg #(.W(DATA_W)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (data),
        .msb   (msb)
    );

    // The register is shifted on the START tick too, so msb always holds the next bit to send.
    always_comb begin
        state_d  = state_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                serial_d = LINE_IDLE;
                if (start) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SYNC;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            ST_SYNC: begin
                if (en) begin
                    state_d  = ST_START;
                    serial_d = START_BIT;
                end
            end
            ST_START: begin
                if (en) begin
                    state_d  = ST_DATA;
                    serial_d = msb;
                    shift    = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_DATA: begin
                if (en) begin
                    shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = ST_STOP;
                        serial_d = STOP_BIT;
`endif
                    end else begin
                        serial_d = msb;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (en) begin
                    state_d  = ST_STOP;
                    serial_d = STOP_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (en) begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = LINE_IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            serial_q <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign serial = serial_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_8bit.sv
// Self-checking bench for uart_tx_8bit: a frame-level model (expected bit
// list per accepted byte) checked every cycle, plus directed literal checks.
module tb_uart_tx_8bit;

    localparam int DW = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_BITS  = 1 + DW + PB + SB;   // start, data, parity, stops
    localparam int FRAME_TICKS = 1 + FRAME_BITS;     // plus the sync period

    logic       clk = 1'b0;
    logic       reset, en, start;
    logic [7:0] data;
    logic       serial, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_8bit #(.DATA_W(DW), .STOP_BITS(SB)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .data   (data),
        .serial (serial),
        .busy   (busy),
        .done   (done)
    );

    // Transmission order of one frame, index 0 first on the line.
    function automatic logic [15:0] frame_of(input logic [7:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1+i] = d[DW-1-i];
        if (PB == 1) f[1+DW] = ^d;
        return f;
    endfunction

    // Frame-level model: idle until start, wait one en, then one bit per en.
    logic        m_valid = 1'b0, m_active = 1'b0, m_sync = 1'b0;
    logic        m_serial = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    logic [15:0] m_frame = '1;
    int          m_pos = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (reset) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_sync   <= 1'b0;
            m_serial <= 1'b1;
            m_busy   <= 1'b0;
        end else if (!m_active) begin
            m_serial <= 1'b1;
            if (start) begin
                m_active <= 1'b1;
                m_sync   <= 1'b1;
                m_busy   <= 1'b1;
                m_frame  <= frame_of(data);
                m_pos    <= 0;
            end
        end else if (en) begin
            if (m_sync) begin
                m_sync   <= 1'b0;
                m_serial <= m_frame[0];
            end else if (m_pos == FRAME_BITS - 1) begin
                m_active <= 1'b0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_serial <= 1'b1;
            end else begin
                m_pos    <= m_pos + 1;
                m_serial <= m_frame[m_pos+1];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends one byte with en every `period` clks; records serial after each en tick.
    task automatic send_frame(input logic [7:0] d, input int period, input logic en_at_start,
                              input int inj_cyc, input logic [7:0] inj_d,
                              output logic [15:0] seq, output int n, output logic [7:0] rx);
        logic was_en;
        seq = '0;
        n   = 0;
        rx  = '0;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        en    = en_at_start;
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
        data  = 8'h00;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            en    = ((cyc % period) == (period - 1));
            start = (cyc == inj_cyc);
            if (cyc == inj_cyc) data = inj_d;
            was_en = en;
            @(negedge clk);
            if (was_en) begin
                seq = {seq[14:0], serial};
                if (n >= 1 && n <= DW) rx = {rx[6:0], serial};
                n++;
            end
            if (done) break;
        end
        en    = 1'b0;
        start = 1'b0;
        check("frame_ticks", n, FRAME_TICKS);
    endtask

    task automatic run_tests();
        logic [15:0] seq;
        int          n, b1, b2, bad;
        logic [7:0]  rx;
        logic [7:0]  rt_vals [3];
        rt_vals = '{8'h00, 8'hFF, 8'h3C};

        reset = 1'b1; en = 1'b0; start = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_serial", serial, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame 0xA5, en every 4 clks.
        send_frame(8'hA5, 4, 1'b0, -1, 8'h00, seq, n, rx);
        check("a5_rx", rx, 8'hA5);
`ifdef UART_TX_PARITY_EN
        check("a5_parity", seq[FRAME_TICKS-10], 0);
        send_frame(8'hA4, 4, 1'b0, -1, 8'h00, seq, n, rx);
        check("a4_parity", seq[FRAME_TICKS-10], 1);
`else
        check("a5_bits", seq[10:1], 10'b0101001011);
`endif

        // Round trip; the last byte also has en coincident with acceptance.
        for (int i = 0; i < 3; i++) begin
            send_frame(rt_vals[i], 3, (i == 2), -1, 8'h00, seq, n, rx);
            check("roundtrip_rx", rx, rt_vals[i]);
        end

        // A start request mid-DATA must be ignored.
        send_frame(8'h12, 4, 1'b0, 14, 8'h34, seq, n, rx);
        check("reject_rx", rx, 8'h12);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            en = (c % 4) == 3;
            @(negedge clk);
            if (busy) bad++;
        end
        en = 1'b0;
        check("no_second_frame", bad, 0);

        // Back-to-back with en tied high.
        en = 1'b1;
        @(negedge clk);
        start = 1'b1; data = 8'h81;
        @(negedge clk);
        start = 1'b0; data = 8'h00;
        b1 = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (busy) b1++;
            @(negedge clk);
        end
        check("b2b_done1", done, 1);
        check("b2b_len1", b1, FRAME_TICKS);
        check("b2b_gap", busy, 0);
        start = 1'b1; data = 8'h7E;
        @(negedge clk);
        start = 1'b0; data = 8'h00;
        check("b2b_restart", busy, 1);
        b2 = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (busy) b2++;
            @(negedge clk);
        end
        check("b2b_done2", done, 1);
        check("b2b_len2", b2, FRAME_TICKS);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame aborts it.
        en = 1'b1;
        start = 1'b1; data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_serial", serial, 1);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!serial || busy || done) bad++;
        end
        check("after_reset_quiet", bad, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; data = 8'h00;
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (m_valid) begin
                        check("model_serial", serial, m_serial);
                        check("model_busy", busy, m_busy);
                        check("model_done", done, m_done);
                    end
                end
            end
            begin
                run_tests();
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
